// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - MIPS-style opcode constants seen by the hazard logic
//   - FSM state encoding for the controller
//   - small decode helpers: which opcodes read rs / rt, which touch data memory
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    // Instruction actually consumes the value in rs.
    function automatic logic reads_rs(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_BEQ) ||
               (op == OP_LW)    || (op == OP_SW);
    endfunction

    // Instruction actually consumes the value in rt (addi/lw write rt instead).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the execute-stage instruction is a load writing a
// non-zero register that the decode-stage instruction actually reads.
// Ports:
//   opcode_step_2        decode-stage opcode
//   rs, rt               decode-stage source register numbers
//   opcode_step_3        execute-stage opcode
//   out_rt_rd_mux_step_3 execute-stage destination register
//   hazard               1 = decode instruction must wait one cycle
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [5:0] opcode_step_2,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [5:0] opcode_step_3,
    input  logic [4:0] out_rt_rd_mux_step_3,
    output logic       hazard
);

    logic producer_is_load;
    logic rs_hit;
    logic rt_hit;

    // Register 0 is hardwired to zero, so a load targeting it never produces
    // a value anyone can depend on.
    assign producer_is_load = (opcode_step_3 == OP_LW) && (out_rt_rd_mux_step_3 != 5'd0);

    // Field matches only count when the field is a real source operand;
    // otherwise an immediate/destination field would cause false stalls.
    assign rs_hit = reads_rs(opcode_step_2) && (rs == out_rt_rd_mux_step_3);
    assign rt_hit = reads_rt(opcode_step_2) && (rt == out_rt_rd_mux_step_3);

    assign hazard = producer_is_load && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Resolves, in priority order: data-memory wait (freeze everything),
// taken branch in execute (flush IF/ID and ID/EX), load-use hazard
// (stall front end and inject a bubble into ID/EX).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   opcode_step_2, rs, rt     decode-stage instruction fields
//   opcode_step_3,
//   out_rt_rd_mux_step_3      execute-stage opcode / destination register
//   beq_taken_step_3          execute-stage beq resolved taken
//   opcode_step_4             memory-stage opcode
//   mem_ready                 data memory completes its access this cycle
//   stall_pc, stall_if_id     hold PC / IF-ID
//   bubble_id_ex              load nop into ID-EX
//   flush_if_id, flush_id_ex  clear IF-ID / ID-EX
//   freeze_all                hold every pipeline register and PC
//   mem_req                   data memory request (memory-stage lw/sw)
//   mem_timeout               sticky memory timeout error
//   stall_count, flush_count  saturating performance counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_step_2,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [5:0]       opcode_step_3,
    input  logic [4:0]       out_rt_rd_mux_step_3,
    input  logic             beq_taken_step_3,
    input  logic [5:0]       opcode_step_4,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_all,
    output logic             mem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic load_use_hit;
    logic mem_busy;

    load_use_detect u_load_use_detect (
        .opcode_step_2        (opcode_step_2),
        .rs                   (rs),
        .rt                   (rt),
        .opcode_step_3        (opcode_step_3),
        .out_rt_rd_mux_step_3 (out_rt_rd_mux_step_3),
        .hazard               (load_use_hit)
    );

    // The request tracks the memory-stage instruction regardless of state or
    // reset, so the memory sees a stable request while the pipe is frozen.
    assign mem_req  = is_mem_op(opcode_step_4);
    assign mem_busy = mem_req && !mem_ready;

    // Control decode and next state.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        freeze_all   = 1'b0;
        state_d      = state_q;

        if (rst) begin
            // Controls stay quiet while reset is held, whatever the inputs.
            state_d = RUN;
        end else if (mem_busy) begin
            // An outstanding memory access overrides everything: nothing may
            // move, including a flush that would otherwise redirect fetch.
            freeze_all = 1'b1;
            state_d    = MEM_WAIT;
        end else begin
            case (state_q)
                BR_FLUSH: begin
                    // The instructions in decode/execute are the ones just
                    // flushed, so neither their beq nor a load-use pairing
                    // is real.
                    state_d = RUN;
                end
                default: begin
                    // RUN, or the release cycle of MEM_WAIT: the pipeline
                    // advances this cycle, so normal hazard rules apply.
                    state_d = RUN;
                    if (beq_taken_step_3) begin
                        // Branch wins over load-use: the dependent
                        // instruction is being flushed anyway.
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        state_d     = BR_FLUSH;
                    end else if (load_use_hit) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory wait tracking and performance counters.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        // Counts consecutive frozen cycles, including the first one seen in
        // RUN; holds at the limit so it cannot wrap back below it.
        if (freeze_all) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            wait_cnt_d = '0;
        end

        if (freeze_all && (wait_cnt_d == WAIT_MAX)) begin
            mem_timeout_d = 1'b1;
        end

        if ((stall_pc || freeze_all) && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end

        if (flush_if_id && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl. The stimulus process
// applies one vector per cycle and queues its hand-computed expectation;
// a separate monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;   // small so counter saturation is reachable

    // control vector bit order: {stall_pc, stall_if_id, bubble_id_ex,
    //                            flush_if_id, flush_id_ex, freeze_all, mem_req}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1110000;
    localparam logic [6:0] C_FLUSH = 7'b0001100;
    localparam logic [6:0] C_FRZ   = 7'b0000011;
    localparam logic [6:0] C_MREQ  = 7'b0000001;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode_step_2;
    logic [4:0]       rs, rt;
    logic [5:0]       opcode_step_3;
    logic [4:0]       out_rt_rd_mux_step_3;
    logic             beq_taken_step_3;
    logic [5:0]       opcode_step_4;
    logic             mem_ready;
    logic             stall_pc, stall_if_id, bubble_id_ex;
    logic             flush_if_id, flush_id_ex, freeze_all;
    logic             mem_req, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .opcode_step_2        (opcode_step_2),
        .rs                   (rs),
        .rt                   (rt),
        .opcode_step_3        (opcode_step_3),
        .out_rt_rd_mux_step_3 (out_rt_rd_mux_step_3),
        .beq_taken_step_3     (beq_taken_step_3),
        .opcode_step_4        (opcode_step_4),
        .mem_ready            (mem_ready),
        .stall_pc             (stall_pc),
        .stall_if_id          (stall_if_id),
        .bubble_id_ex         (bubble_id_ex),
        .flush_if_id          (flush_if_id),
        .flush_id_ex          (flush_id_ex),
        .freeze_all           (freeze_all),
        .mem_req              (mem_req),
        .mem_timeout          (mem_timeout),
        .stall_count          (stall_count),
        .flush_count          (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [6:0]       ctrl;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [6:0] act_ctrl;
    assign act_ctrl = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id,
                       flush_id_ex, freeze_all, mem_req};

    // Drive one cycle of inputs just after the rising edge and queue what the
    // outputs must show during that cycle.
    task automatic apply(input string name, input logic r,
                         input logic [5:0] op2, input logic [4:0] rs_i, input logic [4:0] rt_i,
                         input logic [5:0] op3, input logic [4:0] rd3, input logic beq,
                         input logic [5:0] op4, input logic rdy,
                         input logic [6:0] e_ctrl, input logic e_to, input int e_sc, input int e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        opcode_step_2        = op2;
        rs                   = rs_i;
        rt                   = rt_i;
        opcode_step_3        = op3;
        out_rt_rd_mux_step_3 = rd3;
        beq_taken_step_3     = beq;
        opcode_step_4        = op4;
        mem_ready            = rdy;
        e.name = name;
        e.ctrl = e_ctrl;
        e.to   = e_to;
        e.sc   = e_sc[CNT_W-1:0];
        e.fc   = e_fc[CNT_W-1:0];
        exp_q.push_back(e);
    endtask

    // Idle instruction mix: no register reads, no load, no memory op.
    task automatic idle(input string name, input logic [6:0] e_ctrl, input logic e_to,
                        input int e_sc, input int e_fc);
        apply(name, 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_RTYPE, 1'b1,
              e_ctrl, e_to, e_sc, e_fc);
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if (act_ctrl !== e.ctrl) begin
                    mismatched++;
                    $display("FAIL %s ctrl: got %b expected %b", e.name, act_ctrl, e.ctrl);
                end
                compared++;
                if (mem_timeout !== e.to) begin
                    mismatched++;
                    $display("FAIL %s mem_timeout: got %b expected %b", e.name, mem_timeout, e.to);
                end
                compared++;
                if ({stall_count, flush_count} !== {e.sc, e.fc}) begin
                    mismatched++;
                    $display("FAIL %s counters: got sc=%0d fc=%0d expected sc=%0d fc=%0d",
                             e.name, stall_count, flush_count, e.sc, e.fc);
                end
                $display("txn %-16s ctrl=%b to=%b sc=%0d fc=%0d", e.name, act_ctrl,
                         mem_timeout, stall_count, flush_count);
            end
        end
    end

    // Stimulus.
    initial begin
        rst                  = 1'b1;
        opcode_step_2        = OP_J;
        rs                   = 5'd0;
        rt                   = 5'd0;
        opcode_step_3        = OP_RTYPE;
        out_rt_rd_mux_step_3 = 5'd0;
        beq_taken_step_3     = 1'b0;
        opcode_step_4        = OP_RTYPE;
        mem_ready            = 1'b1;

        // reset held with every hazard asserted: only mem_req may show
        apply("rst_hold", 1'b1, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b1, OP_LW, 1'b0,
              C_MREQ, 1'b0, 0, 0);
        idle("idle_after_rst", C_NONE, 1'b0, 0, 0);

        // load-use cases
        apply("lu_rs", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b0, OP_RTYPE, 1'b1,
              C_STALL, 1'b0, 0, 0);
        idle("idle_1", C_NONE, 1'b0, 1, 0);
        apply("lu_rd0", 1'b0, OP_RTYPE, 5'd0, 5'd0, OP_LW, 5'd0, 1'b0, OP_RTYPE, 1'b1,
              C_NONE, 1'b0, 1, 0);
        apply("addi_rt", 1'b0, OP_ADDI, 5'd1, 5'd7, OP_LW, 5'd7, 1'b0, OP_RTYPE, 1'b1,
              C_NONE, 1'b0, 1, 0);
        apply("addi_rs", 1'b0, OP_ADDI, 5'd7, 5'd0, OP_LW, 5'd7, 1'b0, OP_RTYPE, 1'b1,
              C_STALL, 1'b0, 1, 0);
        apply("sw_rt", 1'b0, OP_SW, 5'd2, 5'd9, OP_LW, 5'd9, 1'b0, OP_RTYPE, 1'b1,
              C_STALL, 1'b0, 2, 0);
        apply("rtype_producer", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_RTYPE, 5'd5, 1'b0, OP_RTYPE, 1'b1,
              C_NONE, 1'b0, 3, 0);

        // branch vs load-use, BR_FLUSH suppression
        apply("br_and_lu", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b1, OP_RTYPE, 1'b1,
              C_FLUSH, 1'b0, 3, 0);
        apply("br_flush_ignore", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b1, OP_RTYPE, 1'b1,
              C_NONE, 1'b0, 3, 1);
        apply("br_alone", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b1, OP_RTYPE, 1'b1,
              C_FLUSH, 1'b0, 3, 1);
        idle("idle_2", C_NONE, 1'b0, 3, 2);

        // short memory wait (branch during freeze must not flush)
        apply("lw_wait_1", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b1, OP_LW, 1'b0,
              C_FRZ, 1'b0, 3, 2);
        apply("lw_wait_2", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_LW, 1'b0,
              C_FRZ, 1'b0, 4, 2);
        apply("lw_wait_3", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_LW, 1'b0,
              C_FRZ, 1'b0, 5, 2);
        apply("lw_release", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_LW, 1'b1,
              C_MREQ, 1'b0, 6, 2);
        idle("idle_3", C_NONE, 1'b0, 6, 2);

        // long memory wait: timeout visible after the 15th frozen cycle,
        // stall counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            apply($sformatf("sw_wait_%0d", k), 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0,
                  OP_SW, 1'b0, C_FRZ, (k >= 16), ((5 + k) > 15) ? 15 : (5 + k), 2);
        end
        apply("sw_release", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_SW, 1'b1,
              C_MREQ, 1'b1, 15, 2);
        idle("idle_sticky", C_NONE, 1'b1, 15, 2);

        // reset in the middle of a memory wait
        for (int k = 1; k <= 3; k++) begin
            apply($sformatf("lw_wait_again_%0d", k), 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0,
                  1'b0, OP_LW, 1'b0, C_FRZ, 1'b1, 15, 2);
        end
        apply("rst_mid_wait", 1'b1, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_LW, 1'b0,
              C_MREQ, 1'b0, 0, 0);
        apply("post_rst_lu", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b0, OP_RTYPE, 1'b1,
              C_STALL, 1'b0, 0, 0);

        // reset during BR_FLUSH must not leave load-use suppressed
        apply("br_before_rst", 1'b0, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b1, OP_RTYPE, 1'b1,
              C_FLUSH, 1'b0, 1, 0);
        apply("rst_in_flush", 1'b1, OP_J, 5'd0, 5'd0, OP_RTYPE, 5'd0, 1'b0, OP_RTYPE, 1'b1,
              C_NONE, 1'b0, 0, 0);
        apply("post_rst_lu2", 1'b0, OP_RTYPE, 5'd5, 5'd0, OP_LW, 5'd5, 1'b0, OP_RTYPE, 1'b1,
              C_STALL, 1'b0, 0, 0);
        idle("idle_end", C_NONE, 1'b0, 1, 0);

        repeat (2) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
